// File: rtl/simd_cs_resolve_pkg.sv
// simd_cs_resolve_pkg: shared SIMD datapath types for the carry-save resolver.
// Provides simd_d_t, simd_lw_t, the stage-1 bundle and the lane-kill decoder.
package simd_cs_resolve_pkg;

  localparam int W = 64;

  typedef logic [W-1:0] simd_d_t;

  typedef enum logic [1:0] {
    LW8  = 2'd0,
    LW16 = 2'd1,
    LW32 = 2'd2,
    LW64 = 2'd3
  } simd_lw_t;

  typedef struct packed {
    logic [31:0] lo;
    logic        c31;
    logic [31:0] sum_hi;
    logic [31:0] carry_hi;
    simd_lw_t    lw;
  } s1_t;

  typedef struct packed {
    simd_d_t  res;
    simd_lw_t lw;
  } s2_t;

  // bit i set: carry into byte i of a 32-bit half is killed
  function automatic logic [3:0] byte_kill(simd_lw_t lw);
    logic [3:0] k;
    unique case (lw)
      LW8:  k = 4'b1110;
      LW16: k = 4'b0100;
      LW32: k = 4'b0000;
      LW64: k = 4'b0000;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/simd_cs_resolve_cpa_seg32.sv
// cpa_seg32: 32-bit lane-segmented adder (a + b + cin), carry killed at lanes.
// Ports: a, b, cin, lw, hi (upper-half flag) -> sum[31:0], cout.
module cpa_seg32
  import simd_cs_resolve_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  simd_lw_t    lw,
  input  logic        hi,
  output logic [31:0] sum,
  output logic        cout
);

  logic [3:0] kill;
  logic       c;
  logic [8:0] t;

  // bit 32 is a lane boundary for every width except LW64
  always_comb begin
    kill = byte_kill(lw);
    c    = hi & cin & (lw == LW64);
    t    = '0;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      if (kill[i]) c = 1'b0;
      t = {1'b0, a[8*i +: 8]}
        + {1'b0, b[8*i +: 8]}
        + {8'd0, c};
      sum[8*i +: 8] = t[7:0];
      c = t[8];
    end
    cout = c;
  end

endmodule

// File: rtl/simd_cs_resolve.sv
// simd_cs_resolve: 2-stage sum/carry -> binary resolver, split at bit 32.
// Ports: clk, rst, in_valid/in_ready/in_sum/in_carry/in_lw, out_valid/out_ready/out_res/out_lw.
module simd_cs_resolve
  import simd_cs_resolve_pkg::*;
#(
  parameter int W = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  simd_d_t  in_sum,
  input  simd_d_t  in_carry,
  input  simd_lw_t in_lw,
  output logic     out_valid,
  input  logic     out_ready,
  output simd_d_t  out_res,
  output simd_lw_t out_lw
);

  localparam int H = W / 2;

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_advance;
  logic        in_fire;
  s1_t         s1_q;
  s2_t         s2_q;
  logic [31:0] lo_sum;
  logic        lo_cout;
  logic [31:0] hi_sum;
  logic        hi_cout_unused;

  assign s1_advance = s1_valid & (~s2_valid | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;

  cpa_seg32 u_lo (
    .a    (in_sum[H-1:0]),
    .b    (in_carry[H-1:0]),
    .cin  (1'b0),
    .lw   (in_lw),
    .hi   (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cpa_seg32 u_hi (
    .a    (s1_q.sum_hi),
    .b    (s1_q.carry_hi),
    .cin  (s1_q.c31),
    .lw   (s1_q.lw),
    .hi   (1'b1),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_fire | (s1_valid & ~s1_advance);
      s2_valid <= s1_advance | (s2_valid & ~out_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_q <= '{lo:       lo_sum,
                c31:      lo_cout,
                sum_hi:   in_sum[W-1:H],
                carry_hi: in_carry[W-1:H],
                lw:       in_lw};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '{res: '0, lw: LW64};
    end else if (s1_advance) begin
      s2_q <= '{res: {hi_sum, s1_q.lo},
                lw:  s1_q.lw};
    end
  end

  assign out_valid = s2_valid;
  assign out_res   = s2_q.res;
  assign out_lw    = s2_q.lw;

endmodule
